// File: rtl/shift_arbiter.sv
// Two-requester arbiter that shares one external combinational 16-bit shifter and
// captures its output into a one-entry tagged result register. Optional macro: SHIFT_ARB_STATS_EN.
module shift_arbiter #(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 4,
  parameter int PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] in0,
  input  logic [CNT_W-1:0]  cnt0,
  input  logic [1:0]        op0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [DATA_W-1:0] in1,
  input  logic [CNT_W-1:0]  cnt1,
  input  logic [1:0]        op1,
  output logic              gnt1,
  output logic [DATA_W-1:0] sh_in,
  output logic [CNT_W-1:0]  sh_cnt,
  output logic [1:0]        sh_op,
  input  logic [DATA_W-1:0] sh_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  input  logic              res_ready
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1,
  output logic              conflict
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} res_state_t;

  res_state_t        state_r, state_s;
  logic              last_gnt_r;
  logic [DATA_W-1:0] res_data_r;
  logic              res_id_r;
  logic              slot_free_s;
  logic              gnt0_s, gnt1_s, accept_s;

  assign res_valid = (state_r == FULL);
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;
  assign gnt0      = gnt0_s;
  assign gnt1      = gnt1_s;
  assign accept_s  = gnt0_s || gnt1_s;

  // Grant selection; nothing is granted while reset is asserted or the slot is occupied
  always_comb begin
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    slot_free_s = rst_n && (!res_valid || res_ready);
    if (slot_free_s) begin
      if (req0 && req1) begin
        if (PRIO_FIXED != 0) begin
          gnt0_s = 1'b1;
        end else if (last_gnt_r) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end else if (req0) begin
        gnt0_s = 1'b1;
      end else if (req1) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
    end
  end

  // Shifter operand mux, zeroed when idle
  always_comb begin
    sh_in  = {DATA_W{1'b0}};
    sh_cnt = {CNT_W{1'b0}};
    sh_op  = 2'b00;
    case ({gnt1_s, gnt0_s})
      2'b01: begin
        sh_in  = in0;
        sh_cnt = cnt0;
        sh_op  = op0;
      end
      2'b10: begin
        sh_in  = in1;
        sh_cnt = cnt1;
        sh_op  = op1;
      end
      default: begin
        sh_in  = {DATA_W{1'b0}};
        sh_cnt = {CNT_W{1'b0}};
        sh_op  = 2'b00;
      end
    endcase
  end

  // Result slot next state; an accept while FULL is a pass-through
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_s = FULL;
        end else begin
          state_s = EMPTY;
        end
      end
      FULL: begin
        if (accept_s) begin
          state_s = FULL;
        end else if (res_ready) begin
          state_s = EMPTY;
        end else begin
          state_s = FULL;
        end
      end
      default: state_s = EMPTY;
    endcase
  end

  // Result slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Result capture and round-robin history; last_gnt resets to 1 so req0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_r <= {DATA_W{1'b0}};
      res_id_r   <= 1'b0;
      last_gnt_r <= 1'b1;
    end else if (accept_s) begin
      res_data_r <= sh_out;
      res_id_r   <= gnt1_s;
      last_gnt_r <= gnt1_s;
    end else begin
      res_data_r <= res_data_r;
      res_id_r   <= res_id_r;
      last_gnt_r <= last_gnt_r;
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] stat_gnt0_r, stat_gnt1_r;

  assign stat_gnt0 = stat_gnt0_r;
  assign stat_gnt1 = stat_gnt1_r;
  assign conflict  = req0 && req1 && slot_free_s;

  // Saturating per-requester grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt0_r <= 16'h0000;
      stat_gnt1_r <= 16'h0000;
    end else begin
      if (gnt0_s && (stat_gnt0_r != 16'hFFFF)) begin
        stat_gnt0_r <= stat_gnt0_r + 16'h0001;
      end else begin
        stat_gnt0_r <= stat_gnt0_r;
      end
      if (gnt1_s && (stat_gnt1_r != 16'hFFFF)) begin
        stat_gnt1_r <= stat_gnt1_r + 16'h0001;
      end else begin
        stat_gnt1_r <= stat_gnt1_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter with a behavioural shifter attached.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, gnt0, gnt1;
  logic [15:0] in0, in1, sh_in, sh_out, res_data;
  logic [3:0]  cnt0, cnt1, sh_cnt;
  logic [1:0]  op0, op1, sh_op;
  logic        res_valid, res_id, res_ready;
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1;
  logic        conflict;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .in0(in0), .cnt0(cnt0), .op0(op0), .gnt0(gnt0),
    .req1(req1), .in1(in1), .cnt1(cnt1), .op1(op1), .gnt1(gnt1),
    .sh_in(sh_in), .sh_cnt(sh_cnt), .sh_op(sh_op), .sh_out(sh_out),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready)
`ifdef SHIFT_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .conflict(conflict)
`endif
  );

  // Behavioural combinational shifter
  logic [4:0] inv_cnt;
  assign inv_cnt = 5'd16 - {1'b0, sh_cnt};
  always_comb begin
    case (sh_op)
      2'b00:   sh_out = (sh_in << sh_cnt) | (sh_in >> inv_cnt);
      2'b01:   sh_out = sh_in << sh_cnt;
      2'b10:   sh_out = (sh_in >> sh_cnt) | (sh_in << inv_cnt);
      default: sh_out = sh_in >> sh_cnt;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    req0 = 1'b0; in0 = 16'h0000; cnt0 = 4'd0; op0 = 2'b00;
    req1 = 1'b0; in1 = 16'h0000; cnt1 = 4'd0; op1 = 2'b00;
    res_ready = 1'b0;
    #2 rst_n = 1'b0;
    req0 = 1'b1;
    #1;
    chk("rst_valid", {15'd0, res_valid}, 16'h0000);
    chk("rst_data", res_data, 16'h0000);
    chk("rst_id", {15'd0, res_id}, 16'h0000);
    chk("rst_nogrant", {15'd0, gnt0}, 16'h0000);
    req0 = 1'b0;
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;

    // single request: ROL 8001 by 1
    req0 = 1'b1; in0 = 16'h8001; cnt0 = 4'd1; op0 = 2'b00;
    #1;
    chk("single_gnt0", {15'd0, gnt0}, 16'h0001);
    chk("single_gnt1", {15'd0, gnt1}, 16'h0000);
    chk("single_shin", sh_in, 16'h8001);
    tick();
    chk("single_valid", {15'd0, res_valid}, 16'h0001);
    chk("single_data", res_data, 16'h0003);
    chk("single_id", {15'd0, res_id}, 16'h0000);

    // ROR by 15 equals ROL by 1
    in0 = 16'h0001; cnt0 = 4'd15; op0 = 2'b10;
    #1;
    chk("ror15_gnt", {15'd0, gnt0}, 16'h0001);
    tick();
    chk("ror15_data", res_data, 16'h0002);
    req0 = 1'b0;

    // cnt=0 passes the operand through for every op
    req1 = 1'b1; in1 = 16'hA5A5; cnt1 = 4'd0;
    for (int i = 0; i < 4; i++) begin
      op1 = i[1:0];
      #1;
      chk("cnt0_gnt1", {15'd0, gnt1}, 16'h0001);
      tick();
      chk("cnt0_data", res_data, 16'hA5A5);
      chk("cnt0_id", {15'd0, res_id}, 16'h0001);
    end

    // park 1234 in the slot, then apply backpressure
    in1 = 16'h1234; op1 = 2'b01;
    tick();
    chk("load_data", res_data, 16'h1234);
    res_ready = 1'b0;
    in1 = 16'h00FF; cnt1 = 4'd4; op1 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_nogrant", {15'd0, gnt1}, 16'h0000);
      tick();
      chk("bp_hold_data", res_data, 16'h1234);
      chk("bp_hold_valid", {15'd0, res_valid}, 16'h0001);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_gnt", {15'd0, gnt1}, 16'h0001);
    tick();
    chk("bp_new_data", res_data, 16'h0FF0);
    chk("bp_new_id", {15'd0, res_id}, 16'h0001);
    req1 = 1'b0;

    // reset mid-operation with a pending result
    req0 = 1'b1; in0 = 16'h1234; cnt0 = 4'd0; op0 = 2'b11;
    tick();
    chk("pre_rst_data", res_data, 16'h1234);
    chk("pre_rst_id", {15'd0, res_id}, 16'h0000);
    res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {15'd0, res_valid}, 16'h0000);
    chk("async_rst_data", res_data, 16'h0000);
    chk("async_rst_nogrant", {15'd0, gnt0}, 16'h0000);
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;

    // round-robin with both requesting continuously
    req0 = 1'b1; in0 = 16'h00FF; cnt0 = 4'd4; op0 = 2'b01;
    req1 = 1'b1; in1 = 16'hF000; cnt1 = 4'd8; op1 = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_gnt0", {15'd0, gnt0}, (i % 2 == 0) ? 16'h0001 : 16'h0000);
      chk("rr_gnt1", {15'd0, gnt1}, (i % 2 == 0) ? 16'h0000 : 16'h0001);
`ifdef SHIFT_ARB_STATS_EN
      chk("rr_conflict", {15'd0, conflict}, 16'h0001);
`endif
      tick();
      chk("rr_data", res_data, (i % 2 == 0) ? 16'h0FF0 : 16'h00F0);
      chk("rr_id", {15'd0, res_id}, (i % 2 == 0) ? 16'h0000 : 16'h0001);
    end
    req0 = 1'b0;
    req1 = 1'b0;
`ifdef SHIFT_ARB_STATS_EN
    chk("stat_gnt0", stat_gnt0, 16'd3);
    chk("stat_gnt1", stat_gnt1, 16'd2);
`endif
    tick();
    chk("drain_valid", {15'd0, res_valid}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
